// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU data-memory arbiter:
// FSM state encoding, starvation default and burst cap.
package pipe_pkg;

  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned BURST_MAX      = 16;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    EXT_ACK   = 2'd1,
    EXT_BURST = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pipe_dmem_mux.sv
// Grant-controlled steering of the single RAM port between the MEM stage
// and the external requester; carries no state.
module pipe_dmem_mux #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              ext_sel_i,
  input  logic              we_en_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              ext_we_i,
  input  logic [ADDR_W-1:0] ext_addr_i,
  input  logic [DATA_W-1:0] ext_wdata_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o
);

  // Address and data follow the CPU whenever the external side is not granted,
  // including idle cycles; only the write enable is qualified.
  assign mem_addr_o  = ext_sel_i ? ext_addr_i  : cpu_addr_i;
  assign mem_wdata_o = ext_sel_i ? ext_wdata_i : cpu_wdata_i;
  assign mem_we_o    = we_en_i & (ext_sel_i ? ext_we_i : cpu_we_i);

endmodule

// File: rtl/pipe_dmem_arbiter.sv
// Data-RAM arbiter between the MEM stage and an external port, with bounded
// starvation. Define PIPE_DMEM_ARB_LOCK_EN to add locked external bursts (ext_lock).
module pipe_dmem_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
`ifdef PIPE_DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              ext_gnt,
  output logic              ext_done,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              ext_done_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic              grant_ext;
  logic              mem_en;

`ifdef PIPE_DMEM_ARB_LOCK_EN
  localparam logic [4:0] BEAT_LIM = 5'(BURST_MAX);
  logic [4:0] beat_q, beat_d;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    grant_ext = 1'b0;
`ifdef PIPE_DMEM_ARB_LOCK_EN
    beat_d    = beat_q;
`endif
    unique case (state_q)
      ARB: begin
        if (ext_req && (!cpu_req || starve_q == STARVE_LIM)) begin
          grant_ext = 1'b1;
`ifdef PIPE_DMEM_ARB_LOCK_EN
          state_d   = ext_lock ? EXT_BURST : EXT_ACK;
          beat_d    = 5'd1;
`else
          state_d   = EXT_ACK;
`endif
        end else if (ext_req && cpu_req) begin
          // The grant branch above takes the saturated case, so this never wraps.
          starve_d = starve_q + 4'd1;
        end
      end
      EXT_ACK: state_d = ARB;
`ifdef PIPE_DMEM_ARB_LOCK_EN
      EXT_BURST: begin
        if (ext_req && ext_lock) begin
          grant_ext = 1'b1;
          beat_d    = beat_q + 5'd1;
          if (beat_q + 5'd1 == BEAT_LIM) state_d = EXT_ACK;
        end else begin
          state_d = EXT_ACK;
        end
      end
`endif
      default: state_d = ARB;
    endcase
    if (grant_ext || !ext_req) starve_d = '0;
    // A grant seen while reset is high would be lost anyway; hide it.
    if (reset) grant_ext = 1'b0;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ARB;
      starve_q    <= '0;
      ext_done_q  <= 1'b0;
      ext_rdata_q <= '0;
`ifdef PIPE_DMEM_ARB_LOCK_EN
      beat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      ext_done_q <= grant_ext;
      if (grant_ext) ext_rdata_q <= mem_rdata;
`ifdef PIPE_DMEM_ARB_LOCK_EN
      beat_q     <= beat_d;
`endif
    end
  end

  assign mem_en    = !reset && (grant_ext || cpu_req);
  assign ext_gnt   = grant_ext;
  assign cpu_stall = grant_ext & cpu_req;
  assign ext_done  = ext_done_q;
  assign ext_rdata = ext_rdata_q;
  assign cpu_rdata = mem_rdata;

  pipe_dmem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .ext_sel_i   (grant_ext),
    .we_en_i     (mem_en),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .ext_we_i    (ext_we),
    .ext_addr_i  (ext_addr),
    .ext_wdata_i (ext_wdata),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata)
  );

endmodule

// File: tb/tb_pipe_dmem_arbiter.sv
// Self-checking bench for pipe_dmem_arbiter: directed steps, then random
// conflict traffic against a behavioural arbitration and RAM model.
module tb_pipe_dmem_arbiter;

  localparam int SMAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        ext_gnt, ext_done;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef PIPE_DMEM_ARB_LOCK_EN
  logic        ext_lock;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  pipe_dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (SMAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
`ifdef PIPE_DMEM_ARB_LOCK_EN
    .ext_lock  (ext_lock),
`endif
    .ext_gnt   (ext_gnt),
    .ext_done  (ext_done),
    .ext_rdata (ext_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // 64-word RAM; read is combinational, standing in for the inverted-clock RAM.
  logic [31:0] ram [64] = '{default: '0};
  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clock) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;

  logic [31:0] ref_mem [64] = '{default: '0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; ext_req = 1'b0; ext_we = 1'b0;
`ifdef PIPE_DMEM_ARB_LOCK_EN
    ext_lock = 1'b0;
`endif
  endtask

  initial begin
    bit          ack;
    bit          exp_gnt;
    bit          exp_xr_valid;
    int          wins;
    int          waitc;
    logic [31:0] exp_xr;
    logic [5:0]  idx;

    reset = 1'b1;
    idle_inputs();
    cpu_addr = '0; cpu_wdata = '0; ext_addr = '0; ext_wdata = '0;
    next_cycle();

    // Reset state
    @(negedge clock);
    check("rst_mem_we", mem_we, 0);
    check("rst_ext_gnt", ext_gnt, 0);
    check("rst_ext_done", ext_done, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    next_cycle();
    reset = 1'b0;

    // CPU-only store then load
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234;
    @(negedge clock);
    check("cpu_st_stall", cpu_stall, 0);
    check("cpu_st_we", mem_we, 1);
    check("cpu_st_addr", mem_addr, 32'h40);
    next_cycle();
    ref_mem[16] = 32'h1234;
    cpu_we = 1'b0;
    @(negedge clock);
    check("cpu_ld_stall", cpu_stall, 0);
    check("cpu_ld_rdata", cpu_rdata, 32'h1234);
    next_cycle();
    cpu_req = 1'b0; cpu_addr = 32'h3C; cpu_wdata = 32'h55;
    @(negedge clock);
    check("idle_we", mem_we, 0);
    check("idle_addr", mem_addr, 32'h3C);
    check("idle_wdata", mem_wdata, 32'h55);
    next_cycle();

    // External-only: write, request held through turnaround, then read
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'hCAFE;
    @(negedge clock);
    check("ext_wr_gnt", ext_gnt, 1);
    check("ext_wr_we", mem_we, 1);
    check("ext_wr_addr", mem_addr, 32'h80);
    check("ext_wr_stall", cpu_stall, 0);
    next_cycle();
    ref_mem[32] = 32'hCAFE;
    ext_we = 1'b0;
    @(negedge clock);
    check("ext_ack_done", ext_done, 1);
    check("ext_ack_gnt", ext_gnt, 0);
    next_cycle();
    @(negedge clock);
    check("ext_rd_gnt", ext_gnt, 1);
    check("ext_rd_done", ext_done, 0);
    next_cycle();
    ext_req = 1'b0;
    @(negedge clock);
    check("ext_rd_done2", ext_done, 1);
    check("ext_rd_data", ext_rdata, 32'hCAFE);
    next_cycle();
    @(negedge clock);
    check("ext_done_pulse", ext_done, 0);
    check("ext_rdata_hold", ext_rdata, 32'hCAFE);
    next_cycle();

    // Starvation bound with continuous CPU loads
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
    for (int i = 0; i < SMAX; i++) begin
      @(negedge clock);
      check("starve_gnt", ext_gnt, 0);
      check("starve_stall", cpu_stall, 0);
      check("starve_cpu_rdata", cpu_rdata, 32'h1234);
      next_cycle();
    end
    @(negedge clock);
    check("forced_gnt", ext_gnt, 1);
    check("forced_stall", cpu_stall, 1);
    check("forced_addr", mem_addr, 32'h80);
    next_cycle();
    ext_req = 1'b0;
    @(negedge clock);
    check("forced_done", ext_done, 1);
    check("forced_ack_stall", cpu_stall, 0);
    check("forced_rdata", ext_rdata, 32'hCAFE);
    next_cycle();
    cpu_req = 1'b0;
    next_cycle();

    // Reset during an external grant cycle
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h84; cpu_wdata = 32'hBAD;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h84; ext_wdata = 32'hBEEF;
    @(negedge clock);
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_gnt", ext_gnt, 0);
    next_cycle();
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
    @(negedge clock);
    check("rstmid_done", ext_done, 0);
    check("rstmid_rdata_clr", ext_rdata, 0);
    check("rstmid_arb_gnt", ext_gnt, 1);
    next_cycle();
    ext_req = 1'b0;
    @(negedge clock);
    check("rstmid_nowrite", ext_rdata, 0);
    next_cycle();

`ifdef PIPE_DMEM_ARB_LOCK_EN
    // Locked burst held far past the cap
    begin
      int stalls;
      stalls = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80; ext_lock = 1'b1;
      for (int i = 0; i < SMAX + 16; i++) begin
        @(negedge clock);
        if (cpu_stall) stalls++;
        next_cycle();
      end
      @(negedge clock);
      check("burst_stall_count", stalls, 16);
      check("burst_ack_stall", cpu_stall, 0);
      check("burst_ack_done", ext_done, 1);
      next_cycle();
      ext_req = 1'b0; ext_lock = 1'b0;
      @(negedge clock);
      check("burst_cpu_served", cpu_stall, 0);
      check("burst_cpu_rdata", cpu_rdata, 32'h1234);
      next_cycle();
    end
`endif

    idle_inputs();
    next_cycle();
    next_cycle();

    // Random conflict traffic against the behavioural model
    ack = 1'b0; wins = 0; waitc = 0; exp_xr = '0; exp_xr_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      idx       = 6'($urandom_range(0, 63));
      cpu_addr  = {24'h0, idx, 2'b00};
      cpu_wdata = $urandom;
      if (ack) begin
        ext_req = 1'b0;
      end else if (!ext_req && $urandom_range(0, 2) == 0) begin
        ext_req   = 1'b1;
        ext_we    = 1'($urandom_range(0, 1));
        idx       = 6'($urandom_range(0, 63));
        ext_addr  = {24'h0, idx, 2'b00};
        ext_wdata = $urandom;
        waitc     = 0;
      end
      exp_gnt = ext_req && !ack && (!cpu_req || wins == SMAX);

      @(negedge clock);
      check("rnd_gnt", ext_gnt, exp_gnt);
      check("rnd_stall", cpu_stall, exp_gnt && cpu_req);
      check("rnd_done", ext_done, ack);
      if (cpu_req && !exp_gnt && !cpu_we)
        check("rnd_cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);
      if (ack && exp_xr_valid)
        check("rnd_ext_rdata", ext_rdata, exp_xr);
      if (exp_gnt)
        check("rnd_ext_wait_bound", (waitc <= SMAX), 1);

      @(posedge clock);
      if (exp_gnt) begin
        exp_xr_valid = !ext_we;
        if (ext_we) ref_mem[ext_addr[7:2]] = ext_wdata;
        else        exp_xr = ref_mem[ext_addr[7:2]];
      end else if (cpu_req && cpu_we) begin
        ref_mem[cpu_addr[7:2]] = cpu_wdata;
      end
      if (!ext_req || exp_gnt)             wins = 0;
      else if (cpu_req && !ack && wins < SMAX) wins++;
      if (ext_req && !exp_gnt) waitc++;
      ack = exp_gnt;
      #1;
    end

    idle_inputs();
    next_cycle();
    next_cycle();
    for (int i = 0; i < 64; i++) check("ram_final", ram[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
